// File: rtl/fp_compare_pipe.sv
`default_nettype none
// ============================================================================
// fp_compare_pipe : two-stage FloPoCo comparator, eight predicates, stallable
// Revision 1.0
// ============================================================================
module fp_compare_pipe #(
  parameter int WE   = 11,
  parameter int WF   = 52,
  parameter int TAGW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WE+WF+2:0]    inA,
  input  logic [WE+WF+2:0]    inB,
  input  logic [2:0]          op,
  input  logic [TAGW-1:0]     in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                result,
  output logic                unordered,
  output logic [TAGW-1:0]     out_tag
);

  localparam int W  = WE + WF + 3;
  localparam int MW = WE + WF;

  localparam logic [1:0] c_exn_zero = 2'b00;
  localparam logic [1:0] c_exn_norm = 2'b01;
  localparam logic [1:0] c_exn_inf  = 2'b10;
  localparam logic [1:0] c_exn_nan  = 2'b11;

  localparam logic [2:0] c_op_eq    = 3'b000;
  localparam logic [2:0] c_op_ne    = 3'b001;
  localparam logic [2:0] c_op_lt    = 3'b010;
  localparam logic [2:0] c_op_le    = 3'b011;
  localparam logic [2:0] c_op_gt    = 3'b100;
  localparam logic [2:0] c_op_ge    = 3'b101;
  localparam logic [2:0] c_op_unord = 3'b110;
  localparam logic [2:0] c_op_ord   = 3'b111;

  // Position on the ordered line -inf < -normal < zero < +normal < +inf.
  function automatic logic [2:0] class_rank(input logic [1:0] exn, input logic sign);
    logic [2:0] rank;
    rank = 3'd2;
    case (exn)
      c_exn_zero: rank = 3'd2;
      c_exn_norm: rank = sign ? 3'd1 : 3'd3;
      c_exn_inf:  rank = sign ? 3'd0 : 3'd4;
      default:    rank = 3'd2;
    endcase
    return rank;
  endfunction

  // ---------------------------------------------------------------- control
  logic w_en;

  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;

  // ---------------------------------------------------------------- stage 1
  logic [MW-1:0] w_mag_a;
  logic [MW-1:0] w_mag_b;
  logic          w_mag_lt;
  logic          w_mag_eq;

  assign w_mag_a  = inA[W-4:0];
  assign w_mag_b  = inB[W-4:0];
  assign w_mag_lt = (w_mag_a < w_mag_b);
  assign w_mag_eq = (w_mag_a == w_mag_b);

  logic            r_s1_valid;
  logic [2:0]      r_s1_op;
  logic [TAGW-1:0] r_s1_tag;
  logic [1:0]      r_s1_exn_a;
  logic [1:0]      r_s1_exn_b;
  logic            r_s1_sign_a;
  logic            r_s1_sign_b;
  logic            r_s1_mag_lt;
  logic            r_s1_mag_eq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= 3'b000;
      r_s1_tag    <= '0;
      r_s1_exn_a  <= c_exn_zero;
      r_s1_exn_b  <= c_exn_zero;
      r_s1_sign_a <= 1'b0;
      r_s1_sign_b <= 1'b0;
      r_s1_mag_lt <= 1'b0;
      r_s1_mag_eq <= 1'b0;
    end else if (w_en) begin
      r_s1_valid  <= in_valid;
      r_s1_op     <= op;
      r_s1_tag    <= in_tag;
      r_s1_exn_a  <= inA[W-1:W-2];
      r_s1_exn_b  <= inB[W-1:W-2];
      r_s1_sign_a <= inA[W-3];
      r_s1_sign_b <= inB[W-3];
      r_s1_mag_lt <= w_mag_lt;
      r_s1_mag_eq <= w_mag_eq;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [2:0] w_rank_a;
  logic [2:0] w_rank_b;
  logic       w_unord;
  logic       w_same_rank;
  logic       w_norm_pair;
  logic       w_lt_ord;
  logic       w_eq_ord;
  logic       w_lt;
  logic       w_eq;
  logic       w_gt;
  logic       w_result;

  assign w_rank_a    = class_rank(r_s1_exn_a, r_s1_sign_a);
  assign w_rank_b    = class_rank(r_s1_exn_b, r_s1_sign_b);
  assign w_unord     = (r_s1_exn_a == c_exn_nan) || (r_s1_exn_b == c_exn_nan);
  assign w_same_rank = (w_rank_a == w_rank_b);
  assign w_norm_pair = w_same_rank && (r_s1_exn_a == c_exn_norm);

  // Two negatives of the same class: the larger magnitude is the smaller value.
  always_comb begin
    w_lt_ord = 1'b0;
    if (!w_same_rank)
      w_lt_ord = (w_rank_a < w_rank_b);
    else if (w_norm_pair)
      w_lt_ord = r_s1_sign_a ? (!r_s1_mag_lt && !r_s1_mag_eq) : r_s1_mag_lt;
  end

  assign w_eq_ord = w_same_rank && (!w_norm_pair || r_s1_mag_eq);
  assign w_lt     = w_lt_ord && !w_unord;
  assign w_eq     = w_eq_ord && !w_unord;
  assign w_gt     = !w_lt && !w_eq && !w_unord;

  always_comb begin
    w_result = 1'b0;
    case (r_s1_op)
      c_op_eq:    w_result = w_eq;
      c_op_ne:    w_result = !w_eq || w_unord;
      c_op_lt:    w_result = w_lt;
      c_op_le:    w_result = w_lt || w_eq;
      c_op_gt:    w_result = w_gt;
      c_op_ge:    w_result = w_gt || w_eq;
      c_op_unord: w_result = w_unord;
      c_op_ord:   w_result = !w_unord;
      default:    w_result = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= 1'b0;
      unordered <= 1'b0;
      out_tag   <= '0;
    end else if (w_en) begin
      out_valid <= r_s1_valid;
      result    <= w_result;
      unordered <= w_unord;
      out_tag   <= r_s1_tag;
    end
  end

endmodule
`default_nettype wire
